scanline_fill_sequencer: RTL

//  Multi-row successor to the single-span fill controller. Sequences a polygon fill over rows y_start..y_end.

---
 rtl/scanline_fill_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/scanline_fill_sequencer.sv
// Multi-row polygon fill sequencer: one edge-math pass, then row fetch and span fill per row,
// with empty-row skip, abort and a per-handshake wait timeout.
module scanline_fill_sequencer #(
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 200
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               fill_en,
  input  logic [COORD_W-1:0] y_start,
  input  logic [COORD_W-1:0] y_end,
  input  logic               abort,
  input  logic               math_done,
  input  logic               row_done,
  input  logic               row_empty,
  input  logic               fill_done,
  output logic               math_start,
  output logic               row_start,
  output logic               fill_start,
  output logic [COORD_W-1:0] row_y,
  output logic               busy,
  output logic               done,
  output logic               err_timeout
);

  typedef enum logic [3:0] {
    IDLE,
    MATH_GO,
    MATH_WAIT,
    ROW_GO,
    ROW_WAIT,
    FILL_GO,
    FILL_WAIT,
    NEXT,
    DONE
  } state_t;

  localparam bit                   TMO_EN   = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               state;
  state_t               state_next;
  logic [COORD_W-1:0]   row_y_next;
  logic [COORD_W-1:0]   y_end_q;
  logic [COORD_W-1:0]   y_end_next;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 waiting;
  logic                 wait_done;
  logic                 timed_out;
  logic                 tmo_fire;

  // Next-state, row counter and timeout decision
  always_comb begin
    state_next = state;
    row_y_next = row_y;
    y_end_next = y_end_q;
    tmo_fire   = 1'b0;

    waiting   = (state == MATH_WAIT) || (state == ROW_WAIT) || (state == FILL_WAIT);
    wait_done = ((state == MATH_WAIT) && math_done) ||
                ((state == ROW_WAIT)  && row_done)  ||
                ((state == FILL_WAIT) && fill_done);
    timed_out = TMO_EN && waiting && !wait_done && (tmo_cnt == TMO_LAST);

    case (state)
      IDLE: begin
        if (fill_en) begin
          y_end_next = y_end;
          row_y_next = y_start;
          state_next = (y_start > y_end) ? DONE : MATH_GO;
        end
      end
      MATH_GO:   state_next = MATH_WAIT;
      MATH_WAIT: if (math_done) state_next = ROW_GO;
      ROW_GO:    state_next = ROW_WAIT;
      ROW_WAIT: begin
        if (row_done) state_next = row_empty ? NEXT : FILL_GO;
      end
      FILL_GO:   state_next = FILL_WAIT;
      FILL_WAIT: if (fill_done) state_next = NEXT;
      NEXT: begin
        // Compare before increment so y_end at the top of the range never wraps
        if (row_y == y_end_q) begin
          state_next = DONE;
        end else begin
          row_y_next = row_y + COORD_W'(1);
          state_next = ROW_GO;
        end
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase

    // Abort outranks both done inputs and the timeout
    if ((state != IDLE) && abort) begin
      state_next = IDLE;
      row_y_next = row_y;
    end else if (timed_out) begin
      state_next = IDLE;
      tmo_fire   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      row_y   <= '0;
      y_end_q <= '0;
    end else begin
      state   <= state_next;
      row_y   <= row_y_next;
      y_end_q <= y_end_next;
    end
  end

  // Wait counter restarts on every entry into a WAIT state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_cnt <= '0;
    end else if (state_next != state) begin
      tmo_cnt <= '0;
    end else if (waiting) begin
      tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
    end
  end

  // Outputs registered alongside the state they belong to
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      math_start  <= 1'b0;
      row_start   <= 1'b0;
      fill_start  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      math_start  <= (state_next == MATH_GO);
      row_start   <= (state_next == ROW_GO);
      fill_start  <= (state_next == FILL_GO);
      busy        <= (state_next != IDLE);
      done        <= (state_next == DONE);
      err_timeout <= tmo_fire;
    end
  end

endmodule
